muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. It uses a shift-add
//               multiplier and a restoring divider that share one
//               2*WIDTH-bit accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    logic [1:0]         r_state,  w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [2:0]         r_op,     w_op_nxt;
    logic [WIDTH-1:0]   r_opb,    w_opb_nxt;
    logic [2*WIDTH-1:0] r_acc,    w_acc_nxt;
    logic               r_neg_q,  w_neg_q_nxt;
    logic               r_neg_r,  w_neg_r_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;

    logic               w_a_sgn, w_b_sgn;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_div_zero, w_div_ovf;
    logic [2*WIDTH-1:0] w_step, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_final;

    // One multiplier bit: add the multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    function automatic logic [2*WIDTH-1:0] f_mul_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   mcand
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
              (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // One quotient bit: the bit shifted out of the top makes the partial
    // remainder at least 2^WIDTH, so the subtraction must happen.
    function automatic logic [2*WIDTH-1:0] f_div_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [WIDTH-1:0]   dvs
    );
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] low;
        logic             ge;
        top = acc[2*WIDTH-2:WIDTH-1];
        low = {acc[WIDTH-2:0], 1'b0};
        ge  = acc[2*WIDTH-1] || (top >= dvs);
        if (ge) begin
            top    = top - dvs;
            low[0] = 1'b1;
        end
        return {top, low};
    endfunction

    assign w_a_sgn = a[WIDTH-1] & ((funct3 == F_MULH) | (funct3 == F_MULHSU) |
                                   (funct3 == F_DIV)  | (funct3 == F_REM));
    assign w_b_sgn = b[WIDTH-1] & ((funct3 == F_MULH) | (funct3 == F_DIV) |
                                   (funct3 == F_REM));
    assign w_mag_a = w_a_sgn ? -a : a;
    assign w_mag_b = w_b_sgn ? -b : b;

    assign w_div_zero = funct3[2] && (b == {WIDTH{1'b0}});
    assign w_div_ovf  = funct3[2] && !funct3[0] && (b == {WIDTH{1'b1}}) &&
                        (a == {1'b1, {(WIDTH-1){1'b0}}});

    always_comb begin
        w_step = r_acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_op[2]) begin
                w_step = f_div_step(w_step, r_opb);
            end else begin
                w_step = f_mul_step(w_step, r_opb);
            end
        end
    end

    // Sign correction is applied to the final accumulator value on the way
    // into the result register.
    assign w_prod = r_neg_q ? -w_step : w_step;
    assign w_quo  = w_step[WIDTH-1:0];
    assign w_rem  = w_step[2*WIDTH-1:WIDTH];

    always_comb begin
        w_final = w_prod[2*WIDTH-1:WIDTH];
        if (r_op[2]) begin
            if (r_op[1]) begin
                w_final = r_neg_r ? -w_rem : w_rem;
            end else begin
                w_final = r_neg_q ? -w_quo : w_quo;
            end
        end else if (r_op[1:0] == 2'b00) begin
            w_final = w_prod[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_opb_nxt    = r_opb;
        w_acc_nxt    = r_acc;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_op_nxt    = funct3;
                    w_neg_q_nxt = w_a_sgn ^ w_b_sgn;
                    w_neg_r_nxt = w_a_sgn;
                    if (w_div_zero) begin
                        w_result_nxt = funct3[1] ? a : {WIDTH{1'b1}};
                        w_state_nxt  = S_DONE;
                    end else if (w_div_ovf) begin
                        w_result_nxt = funct3[1] ? {WIDTH{1'b0}} : a;
                        w_state_nxt  = S_DONE;
                    end else begin
                        // Multiplier (or dividend) sits in the low half.
                        w_acc_nxt   = {{WIDTH{1'b0}}, funct3[2] ? w_mag_a : w_mag_b};
                        w_opb_nxt   = funct3[2] ? w_mag_b : w_mag_a;
                        w_cnt_nxt   = CNT_W'(N);
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt = w_step;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_result_nxt = w_final;
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_op     <= 3'b000;
            r_opb    <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= {WIDTH{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_opb    <= w_opb_nxt;
            r_acc    <= w_acc_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE) && !flush;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit with one default-width
//               single-bit instance and one instance retiring 4 bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    logic             clk;
    logic             rst;
    logic [1:0]       st;
    logic [1:0]       fl;
    logic [1:0][2:0]  fn;
    logic [1:0][31:0] ia;
    logic [1:0][31:0] ib;
    logic [1:0]       o_busy;
    logic [1:0]       o_done;
    logic [1:0][31:0] o_res;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int          m_rem  [2];
    logic [31:0] m_res  [2];
    logic [31:0] m_pend [2];

    muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(st[0]), .funct3(fn[0]), .a(ia[0]), .b(ib[0]),
        .flush(fl[0]), .busy(o_busy[0]), .done(o_done[0]), .result(o_res[0])
    );

    muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(st[1]), .funct3(fn[1]), .a(ia[1]), .b(ib[1]),
        .flush(fl[1]), .busy(o_busy[1]), .done(o_done[1]), .result(o_res[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference computed directly from the RV32M definitions.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            F_MUL:    begin p = ua * ub; return p[31:0]; end
            F_MULH:   begin p = sa * sb; return p[63:32]; end
            F_MULHSU: begin p = sa * ub; return p[63:32]; end
            F_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            F_DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            F_REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default:  begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int lat(input int k, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        if (special) return 1;
        return (k == 0) ? 33 : 9;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-level model: cycles remaining until the operation retires.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_rem[k] <= 0;
                m_res[k] <= 32'd0;
            end else if (fl[k]) begin
                m_rem[k] <= 0;
            end else if (m_rem[k] == 0) begin
                if (st[k]) begin
                    m_rem[k]  <= lat(k, fn[k], ia[k], ib[k]);
                    m_pend[k] <= ref_res(fn[k], ia[k], ib[k]);
                    if (lat(k, fn[k], ia[k], ib[k]) == 1) m_res[k] <= ref_res(fn[k], ia[k], ib[k]);
                end
            end else begin
                m_rem[k] <= m_rem[k] - 1;
                if (m_rem[k] == 2) m_res[k] <= m_pend[k];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy[%0d]", k), {31'b0, o_busy[k]}, {31'b0, m_rem[k] != 0});
                chk($sformatf("done[%0d]", k), {31'b0, o_done[k]}, {31'b0, (m_rem[k] == 1) && !fl[k]});
                chk($sformatf("result[%0d]", k), o_res[k], m_res[k]);
            end
        end
    end

    task automatic issue(input int k, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        st[k] = 1'b1;
        fn[k] = f;
        ia[k] = a;
        ib[k] = b;
    endtask

    // Called in cycle 1 (the first cycle after the start was accepted).
    task automatic wait_done(input int k, input bit hold, input int exp_lat,
                             input bit chk_r, input logic [31:0] exp_r);
        int cyc;
        cyc = 1;
        while (1) begin
            @(negedge clk);
            if (o_done[k]) break;
            chk("busy_during_op", {31'b0, o_busy[k]}, 32'd1);
            if (cyc >= 100) begin
                chk("done_timeout", 32'd0, 32'd1);
                break;
            end
            cyc++;
        end
        if (hold) st[k] = 1'b0;
        chk("latency", cyc, exp_lat);
        if (chk_r) chk("result_literal", o_res[k], exp_r);
    endtask

    task automatic run(input int k, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_r, input bit hold);
        @(posedge clk); #1;
        issue(k, f, a, b);
        @(posedge clk); #1;
        if (!hold) begin
            st[k] = 1'b0;
            fn[k] = 3'($urandom);
            ia[k] = $urandom;
            ib[k] = $urandom;
        end
        wait_done(k, hold, exp_lat, 1'b1, exp_r);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        st  = '0;
        fl  = '0;
        fn  = '0;
        ia  = '0;
        ib  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", {31'b0, o_busy[k]}, 32'd0);
            chk("reset_done", {31'b0, o_done[k]}, 32'd0);
            chk("reset_result", o_res[k], 32'd0);
        end

        run(0, F_MUL,    32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 1'b0);
        run(0, F_MULH,   32'h8000_0000,  32'h8000_0000, 33, 32'h4000_0000, 1'b0);
        run(0, F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 1'b0);
        run(0, F_MULHSU, 32'hFFFF_FFFF,  32'h0000_0002, 33, 32'hFFFF_FFFF, 1'b0);
        run(0, F_DIV,    32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFD, 1'b0);
        run(0, F_REM,    32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFF, 1'b0);
        run(0, F_DIVU,   32'hFFFF_FFF9,  32'd2,         33, 32'h7FFF_FFFC, 1'b0);
        run(0, F_DIVU,   32'd5,          32'd0,          1, 32'hFFFF_FFFF, 1'b0);
        run(0, F_REMU,   32'd5,          32'd0,          1, 32'd5,         1'b0);
        run(0, F_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  1, 32'h8000_0000, 1'b0);
        run(0, F_REM,    32'h8000_0000,  32'hFFFF_FFFF,  1, 32'd0,         1'b0);
        run(0, F_DIV,    32'd100,        32'd7,         33, 32'd14,        1'b0);

        // Flush in CALC cycle 10, restart in the following cycle.
        @(posedge clk); #1;
        issue(0, F_DIV, 32'd1000, 32'd3);
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        fl[0] = 1'b1;
        @(posedge clk); #1;
        fl[0] = 1'b0;
        issue(0, F_DIVU, 32'd1000, 32'd3);
        @(negedge clk);
        chk("flush_busy", {31'b0, o_busy[0]}, 32'd0);
        chk("flush_done", {31'b0, o_done[0]}, 32'd0);
        chk("flush_result", o_res[0], 32'd14);
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_done(0, 1'b0, 33, 1'b1, 32'd333);

        // Reset in CALC cycle 10 discards the operation.
        @(posedge clk); #1;
        issue(0, F_DIV, 32'd1000, 32'd3);
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, o_busy[0]}, 32'd0);
        chk("rst_done", {31'b0, o_done[0]}, 32'd0);
        chk("rst_result", o_res[0], 32'd0);

        // Start and flush together in IDLE: nothing starts.
        @(posedge clk); #1;
        issue(0, F_MUL, 32'd3, 32'd3);
        fl[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        fl[0] = 1'b0;
        @(negedge clk);
        chk("start_flush_busy", {31'b0, o_busy[0]}, 32'd0);

        run(1, F_MUL,  32'h1234_5678, 32'h0000_0010, 9, 32'h2345_6780, 1'b1);
        run(1, F_REM,  32'hFFFF_FFF9, 32'd2,         9, 32'hFFFF_FFFF, 1'b0);
        run(1, F_MULH, 32'h8000_0000, 32'h8000_0000, 9, 32'h4000_0000, 1'b0);

        for (int it = 0; it < 60; it++) begin
            int          k;
            logic [2:0]  f;
            logic [31:0] a, b;
            k = int'($urandom_range(0, 1));
            f = 3'($urandom);
            a = rand_opnd();
            b = rand_opnd();
            if ($urandom_range(0, 5) == 0) begin
                int r;
                r = int'($urandom_range(0, lat(k, f, a, b) - 1));
                @(posedge clk); #1;
                issue(k, f, a, b);
                @(posedge clk); #1;
                st[k] = 1'b0;
                repeat (r) @(posedge clk);
                #1;
                fl[k] = 1'b1;
                @(posedge clk); #1;
                fl[k] = 1'b0;
            end else begin
                @(posedge clk); #1;
                issue(k, f, a, b);
                @(posedge clk); #1;
                st[k] = 1'b0;
                ia[k] = $urandom;
                ib[k] = $urandom;
                wait_done(k, 1'b0, lat(k, f, a, b), 1'b1, ref_res(f, a, b));
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
